// File: rtl/unet_pool_sched.sv
// Layer scheduler for the UNET_IP_maxpool core: walks a small descriptor table,
// drives the core configuration per layer, and tracks start/done handshakes.
module unet_pool_sched #(
  parameter int unsigned NUM_DESC  = 8,
  parameter int unsigned TIMEOUT_W = 20
) (
  input  logic                          clk,
  input  logic                          arst_n,
  input  logic                          cfg_we,
  input  logic [$clog2(NUM_DESC)-1:0]   cfg_idx,
  input  logic [27:0]                   cfg_data,
  input  logic [$clog2(NUM_DESC):0]     num_layers,
  input  logic                          go,
  output logic [6:0]                    mp_channels,
  output logic [6:0]                    mp_height,
  output logic [6:0]                    mp_width,
  output logic [2:0]                    mp_pool_size,
  output logic [2:0]                    mp_stride,
  output logic                          mp_start,
  input  logic                          mp_done,
  output logic                          buf_sel,
  output logic                          busy,
  output logic [$clog2(NUM_DESC)-1:0]   layer_idx,
  output logic                          done,
  output logic                          err,
  output logic [1:0]                    err_code
);

  localparam int unsigned IDX_W = $clog2(NUM_DESC);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_CALC,
    S_START,
    S_WAIT,
    S_NEXT,
    S_FIN
  } state_t;

  state_t               r_state;
  state_t               w_state_nxt;

  logic [27:0]          r_desc [NUM_DESC];
  logic [IDX_W:0]       r_num;
  logic [IDX_W-1:0]     r_layer_idx;
  logic                 r_buf_sel;
  logic                 r_err;
  logic [1:0]           r_err_code;
  logic [6:0]           r_ch;
  logic [6:0]           r_h;
  logic [6:0]           r_w;
  logic [2:0]           r_p;
  logic [2:0]           r_s;
  logic [6:0]           r_rem_h;
  logic [6:0]           r_rem_w;
  logic [6:0]           r_out_h;
  logic [6:0]           r_out_w;
  logic [TIMEOUT_W-1:0] r_wd;

  logic [27:0]          w_desc;
  logic                 w_chain;
  logic [6:0]           w_ld_h;
  logic [6:0]           w_ld_w;
  logic [6:0]           w_ld_p7;
  logic                 w_ld_valid;
  logic [6:0]           w_s7;
  logic                 w_h_ge;
  logic                 w_w_ge;
  logic [TIMEOUT_W-1:0] w_wd_inc;
  logic                 w_wd_term;
  logic [IDX_W:0]       w_idx_inc;
  logic                 w_last;
  logic                 w_busy;
  logic                 w_start;
  logic                 w_done;

  // Table has no reset; only written while no sequence is in flight.
  always_ff @(posedge clk) begin
    if (cfg_we && !w_busy) begin
      r_desc[cfg_idx] <= cfg_data;
    end
  end

  assign w_desc     = r_desc[r_layer_idx];
  assign w_chain    = w_desc[27] && (r_layer_idx != '0);
  assign w_ld_h     = w_chain ? r_out_h : w_desc[13:7];
  assign w_ld_w     = w_chain ? r_out_w : w_desc[20:14];
  assign w_ld_p7    = {4'b0, w_desc[23:21]};
  assign w_ld_valid = (w_desc[6:0] != '0) && (w_desc[23:21] != '0) &&
                      (w_desc[26:24] != '0) &&
                      (w_ld_h >= w_ld_p7) && (w_ld_w >= w_ld_p7);

  assign w_s7       = {4'b0, r_s};
  assign w_h_ge     = (r_rem_h >= w_s7);
  assign w_w_ge     = (r_rem_w >= w_s7);

  assign w_wd_inc   = r_wd + 1'b1;
  assign w_wd_term  = &w_wd_inc;

  assign w_idx_inc  = {1'b0, r_layer_idx} + 1'b1;
  assign w_last     = (w_idx_inc == r_num);

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_busy      = 1'b0;
    w_start     = 1'b0;
    w_done      = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (go) begin
          w_state_nxt = (num_layers != '0) ? S_LOAD : S_FIN;
        end
      end
      S_LOAD: begin
        w_busy      = 1'b1;
        w_state_nxt = w_ld_valid ? S_CALC : S_FIN;
      end
      S_CALC: begin
        w_busy = 1'b1;
        if (!w_h_ge && !w_w_ge) begin
          w_state_nxt = S_START;
        end
      end
      S_START: begin
        w_busy      = 1'b1;
        w_start     = 1'b1;
        w_state_nxt = S_WAIT;
      end
      S_WAIT: begin
        w_busy = 1'b1;
        // A done pulse on the terminal-count cycle still wins over the timeout.
        if (mp_done) begin
          w_state_nxt = S_NEXT;
        end else if (w_wd_term) begin
          w_state_nxt = S_FIN;
        end
      end
      S_NEXT: begin
        w_busy      = 1'b1;
        w_state_nxt = w_last ? S_FIN : S_LOAD;
      end
      S_FIN: begin
        w_done      = 1'b1;
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      r_num       <= '0;
      r_layer_idx <= '0;
      r_buf_sel   <= 1'b0;
      r_err       <= 1'b0;
      r_err_code  <= '0;
      r_ch        <= '0;
      r_h         <= '0;
      r_w         <= '0;
      r_p         <= '0;
      r_s         <= '0;
      r_rem_h     <= '0;
      r_rem_w     <= '0;
      r_out_h     <= '0;
      r_out_w     <= '0;
      r_wd        <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (go) begin
            r_err      <= 1'b0;
            r_err_code <= '0;
            if (num_layers != '0) begin
              r_num       <= num_layers;
              r_layer_idx <= '0;
              r_buf_sel   <= 1'b0;
            end
          end
        end
        S_LOAD: begin
          r_ch    <= w_desc[6:0];
          r_h     <= w_ld_h;
          r_w     <= w_ld_w;
          r_p     <= w_desc[23:21];
          r_s     <= w_desc[26:24];
          // r_out_* is read above for chaining before being restarted here.
          r_rem_h <= w_ld_h - w_ld_p7;
          r_rem_w <= w_ld_w - w_ld_p7;
          r_out_h <= 7'd1;
          r_out_w <= 7'd1;
          if (!w_ld_valid) begin
            r_err      <= 1'b1;
            r_err_code <= 2'd1;
          end
        end
        S_CALC: begin
          if (w_h_ge) begin
            r_rem_h <= r_rem_h - w_s7;
            r_out_h <= r_out_h + 7'd1;
          end
          if (w_w_ge) begin
            r_rem_w <= r_rem_w - w_s7;
            r_out_w <= r_out_w + 7'd1;
          end
        end
        S_START: begin
          r_wd <= '0;
        end
        S_WAIT: begin
          r_wd <= w_wd_inc;
          if (!mp_done && w_wd_term) begin
            r_err      <= 1'b1;
            r_err_code <= 2'd2;
          end
        end
        S_NEXT: begin
          r_buf_sel <= ~r_buf_sel;
          if (!w_last) begin
            r_layer_idx <= w_idx_inc[IDX_W-1:0];
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign mp_channels  = r_ch;
  assign mp_height    = r_h;
  assign mp_width     = r_w;
  assign mp_pool_size = r_p;
  assign mp_stride    = r_s;
  assign mp_start     = w_start;
  assign buf_sel      = r_buf_sel;
  assign busy         = w_busy;
  assign layer_idx    = r_layer_idx;
  assign done         = w_done;
  assign err          = r_err;
  assign err_code     = r_err_code;

endmodule

// File: tb/tb_unet_pool_sched.sv
// Directed bench for unet_pool_sched: a per-run expected-cycle trace derived from
// the layer latency rules plus literal checks on key results.
module tb_unet_pool_sched;

  localparam int TW = 4;
  localparam int TO = (1 << TW) - 1;

  logic       clk;
  logic       arst_n;
  logic       cfg_we;
  logic [2:0] cfg_idx;
  logic [27:0] cfg_data;
  logic [3:0] num_layers;
  logic       go;
  logic [6:0] mp_channels, mp_height, mp_width;
  logic [2:0] mp_pool_size, mp_stride;
  logic       mp_start, mp_done, buf_sel, busy, done, err;
  logic [2:0] layer_idx;
  logic [1:0] err_code;

  unet_pool_sched #(.NUM_DESC(8), .TIMEOUT_W(TW)) dut (
    .clk(clk), .arst_n(arst_n), .cfg_we(cfg_we), .cfg_idx(cfg_idx),
    .cfg_data(cfg_data), .num_layers(num_layers), .go(go),
    .mp_channels(mp_channels), .mp_height(mp_height), .mp_width(mp_width),
    .mp_pool_size(mp_pool_size), .mp_stride(mp_stride), .mp_start(mp_start),
    .mp_done(mp_done), .buf_sel(buf_sel), .busy(busy), .layer_idx(layer_idx),
    .done(done), .err(err), .err_code(err_code)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit busy, start, done, bsel, err, chk_mp;
    int idx, code, ch, h, w, p, s;
  } exp_t;

  typedef struct {
    int ch, h, w, p, s, c;
  } desc_t;

  exp_t  exp_q[$];
  desc_t m_desc[8];
  int    m_idx, m_code;
  bit    m_buf, m_err;

  int    vectors, miscompares;
  int    cyc, start_cnt, done_cnt, start_cyc, to_cyc, last_h, last_w;
  int    core_delay;
  string cur_name;

  function automatic exp_t rec(bit b, bit st, bit dn, bit bf, int idx, bit er, int cd);
    exp_t e;
    e.busy = b; e.start = st; e.done = dn; e.bsel = bf; e.idx = idx;
    e.err = er; e.code = cd; e.chk_mp = 0;
    e.ch = 0; e.h = 0; e.w = 0; e.p = 0; e.s = 0;
    return e;
  endfunction

  // Expected per-cycle trace from the cycle after go is sampled until one idle cycle past FIN.
  task automatic build_run(input int n, input int d);
    exp_t e;
    desc_t ds;
    int h, w, oh, ow, qh, qw, nc;
    bit bf;
    m_err = 0; m_code = 0;
    if (n == 0) begin
      exp_q.push_back(rec(0, 0, 1, m_buf, m_idx, 0, 0));
      exp_q.push_back(rec(0, 0, 0, m_buf, m_idx, 0, 0));
      return;
    end
    bf = 0; oh = 0; ow = 0;
    for (int i = 0; i < n; i++) begin
      ds = m_desc[i];
      h = ds.h; w = ds.w;
      if (ds.c != 0 && i > 0) begin h = oh; w = ow; end
      exp_q.push_back(rec(1, 0, 0, bf, i, 0, 0));
      if (ds.ch == 0 || ds.p == 0 || ds.s == 0 || h < ds.p || w < ds.p) begin
        exp_q.push_back(rec(0, 0, 1, bf, i, 1, 1));
        exp_q.push_back(rec(0, 0, 0, bf, i, 1, 1));
        m_idx = i; m_buf = bf; m_err = 1; m_code = 1;
        return;
      end
      qh = (h - ds.p) / ds.s; qw = (w - ds.p) / ds.s;
      oh = qh + 1; ow = qw + 1;
      nc = ((qh > qw) ? qh : qw) + 1;
      e = rec(1, 0, 0, bf, i, 0, 0);
      e.chk_mp = 1; e.ch = ds.ch; e.h = h; e.w = w; e.p = ds.p; e.s = ds.s;
      for (int k = 0; k < nc; k++) exp_q.push_back(e);
      e.start = 1; exp_q.push_back(e); e.start = 0;
      if (d == 0 || d > TO) begin
        for (int k = 0; k < TO; k++) exp_q.push_back(e);
        exp_q.push_back(rec(0, 0, 1, bf, i, 1, 2));
        exp_q.push_back(rec(0, 0, 0, bf, i, 1, 2));
        m_idx = i; m_buf = bf; m_err = 1; m_code = 2;
        return;
      end
      for (int k = 0; k < d; k++) exp_q.push_back(e);
      exp_q.push_back(e);
      bf = !bf;
    end
    exp_q.push_back(rec(0, 0, 1, bf, n - 1, 0, 0));
    exp_q.push_back(rec(0, 0, 0, bf, n - 1, 0, 0));
    m_idx = n - 1; m_buf = bf;
  endtask

  always @(negedge clk) begin
    exp_t e;
    bit bad;
    cyc++;
    if (mp_start) begin
      start_cnt++; start_cyc = cyc; last_h = mp_height; last_w = mp_width;
    end
    if (done) done_cnt++;
    if (err_code == 2'd2 && to_cyc == 0) to_cyc = cyc;
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      bad = (busy !== e.busy) || (mp_start !== e.start) || (done !== e.done) ||
            (buf_sel !== e.bsel) || (err !== e.err) ||
            (int'(layer_idx) != e.idx) || (int'(err_code) != e.code);
      if (e.chk_mp)
        bad = bad || (int'(mp_channels) != e.ch) || (int'(mp_height) != e.h) ||
              (int'(mp_width) != e.w) || (int'(mp_pool_size) != e.p) ||
              (int'(mp_stride) != e.s);
      vectors++;
      if (bad) begin
        miscompares++;
        $display("FAIL %s cyc%0d busy/start/done/buf/idx/err/code act=%0d/%0d/%0d/%0d/%0d/%0d/%0d exp=%0d/%0d/%0d/%0d/%0d/%0d/%0d ch/h/w/p/s act=%0d/%0d/%0d/%0d/%0d exp=%0d/%0d/%0d/%0d/%0d(chk=%0d)",
                 cur_name, cyc, busy, mp_start, done, buf_sel, layer_idx, err, err_code,
                 e.busy, e.start, e.done, e.bsel, e.idx, e.err, e.code,
                 mp_channels, mp_height, mp_width, mp_pool_size, mp_stride,
                 e.ch, e.h, e.w, e.p, e.s, e.chk_mp);
      end
    end
  end

  // Core stand-in: pulses mp_done core_delay cycles after seeing mp_start (0 = never).
  initial begin
    mp_done = 1'b0;
    forever begin
      @(negedge clk);
      if (mp_start === 1'b1 && core_delay > 0) begin
        repeat (core_delay) @(posedge clk);
        #1 mp_done = 1'b1;
        @(posedge clk);
        #1 mp_done = 1'b0;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input int act, input int expv);
    vectors++;
    if (act != expv) begin
      miscompares++;
      $display("FAIL %s act=%0d exp=%0d", nm, act, expv);
    end
  endtask

  task automatic wr(input int idx, input int ch, input int h, input int w,
                    input int p, input int s, input int c);
    cfg_we = 1'b1;
    cfg_idx = 3'(idx);
    cfg_data = {1'(c), 3'(s), 3'(p), 7'(w), 7'(h), 7'(ch)};
    tick();
    cfg_we = 1'b0;
    m_desc[idx] = '{ch: ch, h: h, w: w, p: p, s: s, c: c};
  endtask

  task automatic clr_stats();
    start_cnt = 0; done_cnt = 0; start_cyc = 0; to_cyc = 0; last_h = 0; last_w = 0;
  endtask

  task automatic run(input string nm, input int n, input int d);
    cur_name = nm;
    core_delay = d;
    clr_stats();
    go = 1'b1;
    num_layers = 4'(n);
    tick();
    go = 1'b0;
    build_run(n, d);
  endtask

  task automatic drain();
    for (int k = 0; k < 3000 && exp_q.size() != 0; k++) tick();
    if (exp_q.size() != 0) begin
      vectors++;
      miscompares++;
      $display("FAIL %s drain act=%0d pending exp=0 pending", cur_name, exp_q.size());
      exp_q.delete();
    end
  endtask

  initial begin
    vectors = 0; miscompares = 0; cyc = 0; core_delay = 0;
    m_idx = 0; m_buf = 0; m_err = 0; m_code = 0;
    cur_name = "init";
    clr_stats();
    arst_n = 1'b0; cfg_we = 1'b0; cfg_idx = '0; cfg_data = '0;
    num_layers = '0; go = 1'b0;
    repeat (3) tick();
    chk("rst_busy", busy, 0);
    chk("rst_start", mp_start, 0);
    chk("rst_done", done, 0);
    chk("rst_bufsel_idx_err", {buf_sel, layer_idx, err, err_code}, 0);
    chk("rst_mp", {mp_channels, mp_height, mp_width, mp_pool_size, mp_stride}, 0);
    arst_n = 1'b1;
    tick();

    // single layer, 64x64 pool 2 stride 2 -> out 32
    wr(0, 64, 64, 64, 2, 2, 0);
    run("basic", 1, 10);
    drain();
    chk("basic_mp_height", last_h, 64);
    chk("basic_starts", start_cnt, 1);
    chk("basic_done", done_cnt, 1);
    chk("basic_bufsel", buf_sel, 1);
    chk("basic_err", err, 0);

    // chained second layer takes 32x16 from the first layer's output
    wr(0, 8, 64, 32, 2, 2, 0);
    wr(1, 8, 5, 5, 2, 2, 1);
    run("chain", 2, 3);
    drain();
    chk("chain_h", last_h, 32);
    chk("chain_w", last_w, 16);
    chk("chain_bufsel", buf_sel, 0);
    chk("chain_starts", start_cnt, 2);

    wr(0, 8, 2, 8, 3, 1, 0);
    run("invalid", 1, 5);
    drain();
    chk("inv_starts", start_cnt, 0);
    chk("inv_err", err, 1);
    chk("inv_code", err_code, 1);
    chk("inv_idx", layer_idx, 0);
    chk("inv_done", done_cnt, 1);

    run("zero", 0, 5);
    drain();
    chk("zero_starts", start_cnt, 0);
    chk("zero_done", done_cnt, 1);
    chk("zero_err_cleared", err, 0);

    wr(0, 1, 4, 4, 2, 2, 0);
    run("timeout", 1, 0);
    drain();
    chk("to_wait_cycles", to_cyc - start_cyc - 1, 15);
    chk("to_code", err_code, 2);
    chk("to_done", done_cnt, 1);

    run("terminal", 1, 15);
    drain();
    chk("term_err", err, 0);
    chk("term_bufsel", buf_sel, 1);

    // go and cfg_we while busy must both be dropped
    wr(0, 5, 20, 12, 4, 3, 0);
    run("busy", 1, 20);
    repeat (5) tick();
    go = 1'b1; num_layers = 4'd2;
    cfg_we = 1'b1; cfg_idx = 3'd0; cfg_data = {1'b0, 3'd1, 3'd1, 7'd9, 7'd9, 7'd9};
    tick();
    go = 1'b0; cfg_we = 1'b0;
    drain();
    chk("busy_starts", start_cnt, 1);
    run("readback", 1, 2);
    drain();
    chk("readback_h", last_h, 20);
    chk("readback_w", last_w, 12);

    // reset while waiting on the core
    run("midrst", 1, 0);
    for (int k = 0; k < 500 && start_cnt == 0; k++) tick();
    chk("midrst_started", start_cnt, 1);
    repeat (3) tick();
    arst_n = 1'b0;
    exp_q.delete();
    m_idx = 0; m_buf = 0; m_err = 0; m_code = 0;
    done_cnt = 0;
    @(negedge clk);
    chk("midrst_busy", busy, 0);
    chk("midrst_start", mp_start, 0);
    chk("midrst_state", {done, buf_sel, layer_idx, err, err_code}, 0);
    tick();
    arst_n = 1'b1;
    repeat (20) tick();
    chk("midrst_no_done", done_cnt, 0);
    run("postrst", 1, 4);
    drain();
    chk("postrst_starts", start_cnt, 1);
    chk("postrst_done", done_cnt, 1);
    chk("postrst_h", last_h, 20);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
